// File: rtl/_serial_logic16.sv
// Bit-serial 16-bit AND / NOT unit that produces one result bit per cycle behind a valid/ready handshake.
// Optional macro SERIAL_LOGIC16_PROGRESS_EN adds the out_idx progress port.

module _and (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a & b;
endmodule

module _not (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module _serial_logic16 #(
  parameter int N = 16
) (
  input  logic         in_clk,
  input  logic         in_rst_n,
  input  logic [0:N-1] in_a,
  input  logic [0:N-1] in_b,
  input  logic         in_op,
  input  logic         in_valid,
  input  logic         in_ready,
  output logic         out_ready,
  output logic [0:N-1] out_y,
  output logic         out_valid
`ifdef SERIAL_LOGIC16_PROGRESS_EN
  ,
  output logic [0:3]   out_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t       state;
  state_t       state_next;
  logic [0:N-1] a_q;
  logic [0:N-1] b_q;
  logic         op_q;
  logic [3:0]   idx;
  logic         a_bit;
  logic         b_bit;
  logic         and_bit;
  logic         not_bit;
  logic         res_bit;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = SHIFT;
      SHIFT:   if (idx == 4'd15) state_next = DONE;
      DONE:    if (in_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign out_ready = (state == IDLE);
  assign out_valid = (state == DONE);

  // Only the selected operand bits reach the primitives; the result word fills in MSB first.
  assign a_bit = a_q[idx];
  assign b_bit = b_q[idx];

  _and u_and (
    .a (a_bit),
    .b (b_bit),
    .y (and_bit)
  );

  _not u_not (
    .a (a_bit),
    .y (not_bit)
  );

  assign res_bit = op_q ? not_bit : and_bit;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= 1'b0;
      idx   <= 4'd0;
      out_y <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q  <= in_a;
        b_q  <= in_b;
        op_q <= in_op;
        idx  <= 4'd0;
      end
      // idx wraps back to 0 on the last bit, so it already reads 0 in DONE.
      if (state == SHIFT) begin
        out_y[idx] <= res_bit;
        idx        <= idx + 4'd1;
      end
    end
  end

`ifdef SERIAL_LOGIC16_PROGRESS_EN
  assign out_idx = (state == SHIFT) ? idx : 4'd0;
`endif

endmodule

// File: tb/tb__serial_logic16.sv
// Scoreboard bench for _serial_logic16: expected words are queued at accept and compared when out_valid rises.
// Define SERIAL_LOGIC16_PROGRESS_EN to also check the out_idx progress port.

module tb__serial_logic16;

  logic        in_clk;
  logic        in_rst_n;
  logic [0:15] in_a;
  logic [0:15] in_b;
  logic        in_op;
  logic        in_valid;
  logic        in_ready;
  logic        out_ready;
  logic [0:15] out_y;
  logic        out_valid;
`ifdef SERIAL_LOGIC16_PROGRESS_EN
  logic [0:3]  out_idx;
`endif

  int          totalChecks;
  int          badChecks;
  logic [0:15] expQ[$];
  logic [0:15] lastExp;

  _serial_logic16 #(.N(16)) dut (
    .in_clk    (in_clk),
    .in_rst_n  (in_rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_valid (out_valid)
`ifdef SERIAL_LOGIC16_PROGRESS_EN
    ,
    .out_idx   (out_idx)
`endif
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Wait for out_ready, present one request for a single edge and queue its expected result.
  task automatic applyStimulus(input logic [0:15] a, input logic [0:15] b, input logic op);
    int waitCycles;
    waitCycles = 0;
    while (out_ready !== 1'b1 && waitCycles < 40) begin
      @(posedge in_clk);
      @(negedge in_clk);
      waitCycles++;
    end
    checkOutput("accept_ready", 16'(out_ready), 16'd1);
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    expQ.push_back(op ? ~a : (a & b));
    @(posedge in_clk);
    @(negedge in_clk);
    in_valid = 1'b0;
  endtask

  // Step through SHIFT until out_valid; optionally disturb the inputs or reset at a given bit index.
  task automatic waitResult(input int disturbAt, input int resetAt);
    int          cycles;
    logic [0:15] exp;
    cycles = 0;
    exp    = '0;
    if (expQ.size() == 0) begin
      checkOutput("queue_empty", 16'd1, 16'd0);
    end else begin
      exp = expQ.pop_front();
    end
    while (out_valid !== 1'b1 && cycles < 40) begin
      checkOutput("busy_ready", 16'(out_ready), 16'd0);
`ifdef SERIAL_LOGIC16_PROGRESS_EN
      checkOutput("progress_idx", 16'(out_idx), 16'(cycles[3:0]));
`endif
      if (cycles == disturbAt) begin
        in_a     = 16'h5555;
        in_b     = 16'h0000;
        in_op    = 1'b1;
        in_valid = 1'b1;
      end
      if (cycles == resetAt) begin
        in_rst_n = 1'b0;
        @(posedge in_clk);
        @(negedge in_clk);
        checkOutput("abort_y", out_y, 16'h0000);
        checkOutput("abort_valid", 16'(out_valid), 16'd0);
        checkOutput("abort_ready", 16'(out_ready), 16'd1);
        in_rst_n = 1'b1;
        in_valid = 1'b0;
        return;
      end
      @(posedge in_clk);
      cycles++;
      @(negedge in_clk);
    end
    checkOutput("latency", cycles[15:0], 16'd16);
    checkOutput("result", out_y, exp);
`ifdef SERIAL_LOGIC16_PROGRESS_EN
    checkOutput("done_idx", 16'(out_idx), 16'd0);
`endif
    lastExp = exp;
  endtask

  // Hold off in_ready while junk requests arrive, then release the result.
  task automatic handOff(input int holdCycles);
    for (int i = 0; i < holdCycles; i++) begin
      in_a     = 16'hFFFF;
      in_b     = 16'hFFFF;
      in_op    = 1'b0;
      in_valid = 1'b1;
      checkOutput("hold_valid", 16'(out_valid), 16'd1);
      checkOutput("hold_y", out_y, lastExp);
      checkOutput("hold_ready", 16'(out_ready), 16'd0);
      @(posedge in_clk);
      @(negedge in_clk);
    end
    in_valid = 1'b0;
    in_ready = 1'b1;
    @(posedge in_clk);
    @(negedge in_clk);
    in_ready = 1'b0;
    checkOutput("idle_ready", 16'(out_ready), 16'd1);
    checkOutput("idle_valid", 16'(out_valid), 16'd0);
    checkOutput("idle_y_kept", out_y, lastExp);
  endtask

  initial begin
    logic [31:0] r;
    totalChecks = 0;
    badChecks   = 0;
    lastExp     = '0;
    in_rst_n    = 1'b0;
    in_a        = 16'h0000;
    in_b        = 16'h0000;
    in_op       = 1'b0;
    in_valid    = 1'b0;
    in_ready    = 1'b0;
    repeat (3) @(posedge in_clk);
    @(negedge in_clk);
    checkOutput("reset_y", out_y, 16'h0000);
    checkOutput("reset_valid", 16'(out_valid), 16'd0);
    checkOutput("reset_ready", 16'(out_ready), 16'd1);
`ifdef SERIAL_LOGIC16_PROGRESS_EN
    checkOutput("reset_idx", 16'(out_idx), 16'd0);
`endif
    in_rst_n = 1'b1;

    applyStimulus(16'hF0F0, 16'hFF00, 1'b0);
    waitResult(-1, -1);
    handOff(10);

    applyStimulus(16'h1234, 16'hFFFF, 1'b1);
    waitResult(-1, -1);
    handOff(0);
    applyStimulus(16'h1234, 16'h0000, 1'b1);
    waitResult(-1, -1);
    handOff(1);

    applyStimulus(16'hAAAA, 16'hFFFF, 1'b0);
    waitResult(5, -1);
    handOff(2);

    applyStimulus(16'hC3C3, 16'hFFFF, 1'b0);
    waitResult(-1, 8);
    applyStimulus(16'h00FF, 16'h0F0F, 1'b0);
    waitResult(-1, -1);
    handOff(0);

    for (int k = 0; k < 4; k++) begin
      logic [0:15] ra;
      logic [0:15] rb;
      r  = $urandom;
      ra = r[15:0];
      r  = $urandom;
      rb = r[15:0];
      applyStimulus(ra, rb, k[0]);
      waitResult(-1, -1);
      handOff(k);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/_serial_logic16.md
_SERIAL_LOGIC16 -- requirements
Module: _serial_logic16

Interface
REQ-001 Parameter: N, default 16, operand/result width in bits; only N = 16 is supported.
REQ-002 in_clk  input  1  single clock; all state updates on rising edge.
REQ-003 in_rst_n  input  1  synchronous, active-low reset, sampled on rising edge of in_clk.
REQ-004 in_a  input  [0:15]  operand A; index 0 is the MSB.
REQ-005 in_b  input  [0:15]  operand B; ignored when in_op = 1.
REQ-006 in_op  input  1  0 = AND(A,B), 1 = NOT(A).
REQ-007 in_valid  input  1  upstream request valid.
REQ-008 out_ready  output  1  block can accept a request.
REQ-009 out_y  output  [0:15]  result word.
REQ-010 out_valid  output  1  out_y holds a completed result.
REQ-011 in_ready  input  1  downstream accepts the result.

Function
REQ-012 The block SHALL compute the result bit-serially, one bit per cycle, using one _and and one _not primitive instance; no 16-wide parallel logic on the operand path.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 out_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 IDLE: on an edge with in_valid=1, the block SHALL latch in_a, in_b and in_op, clear the 4-bit index to 0 and enter SHIFT; otherwise it stays in IDLE.
REQ-016 SHIFT: each edge SHALL write out_y[idx] = op ? ~a[idx] : a[idx]&b[idx] from the latched operands, then increment idx.
REQ-017 SHIFT SHALL process indices 0 through 15 in ascending order; the edge that writes index 15 SHALL move to DONE. idx wraps 15->0 and is not used in DONE.
REQ-018 Latency: with an accept at edge E0, out_valid SHALL be 1 from edge E16 onward; exactly 16 SHIFT edges occur.
REQ-019 in_a, in_b, in_op and in_valid changing during SHIFT or DONE SHALL have no effect.
REQ-020 DONE: out_y and out_valid SHALL hold stable until an edge with in_ready=1, which SHALL move to IDLE. out_y SHALL keep its value in IDLE.
REQ-021 A new request SHALL NOT be accepted in the same cycle as result hand-off; minimum request-to-request period is 18 cycles.
REQ-022 While in SHIFT, out_y bits not yet written SHALL keep their previous values.

Reset
REQ-023 On an edge with in_rst_n=0, the block SHALL enter IDLE, set out_y=0, out_valid=0, out_ready=1, idx=0, and clear the latched operands and op.
REQ-024 Reset during SHIFT or DONE SHALL abort the operation with no result delivered; the first accept after reset release follows REQ-015.
REQ-025 Reset SHALL take priority over all handshakes on the same edge.

Configuration
REQ-026 When macro SERIAL_LOGIC16_PROGRESS_EN is defined, the block SHALL add an output port out_idx [0:3] that exposes idx; the port SHALL read 0 in IDLE and DONE and 0..15 during SHIFT.
REQ-027 When SERIAL_LOGIC16_PROGRESS_EN is undefined, out_idx SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 AND: in_a=0xF0F0, in_b=0xFF00, in_op=0, accept at E0 -> out_valid at E16, out_y=0xF000.
REQ-029 NOT: in_a=0x1234, in_b=0xFFFF, in_op=1 -> out_y=0xEDCB; in_b has no effect.
REQ-030 Backpressure: in_ready=0 for 10 cycles after DONE -> out_valid and out_y=0xF000 held, out_ready=0, a new in_valid is ignored; in_ready=1 -> IDLE the next cycle.
REQ-031 Operand change mid-shift: in_a=0xAAAA, in_b=0xFFFF accepted, then in_a driven to 0x5555 at idx 5 -> result 0xAAAA.
REQ-032 Reset mid-shift: in_rst_n=0 at idx 8 -> out_y=0, out_valid=0, out_ready=1 next edge; a following request 0x00FF AND 0x0F0F -> 0x000F with 16-cycle latency.
REQ-033 With SERIAL_LOGIC16_PROGRESS_EN: out_idx steps 0..15 across SHIFT cycles and reads 0 in DONE.
